// File: rtl/branch_resolve_ctrl.sv
// Execute-stage branch resolution: drives the comparator opcode, checks the
// fetch prediction, and sequences the redirect/flush handshake on a mispredict.
module branch_resolve_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic             ex_is_br,
  input  logic             ex_is_jal,
  input  logic             ex_is_jalr,
  input  logic [2:0]       ex_cmpop,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      ex_target,
  input  logic             ex_pred_taken,
  input  logic [31:0]      ex_pred_target,
  output logic [2:0]       cmpop,
  input  logic [31:0]      cmp_br_en,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  input  logic             redirect_ready,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             ex_stall,
  output logic             bp_upd_valid,
  output logic [31:0]      bp_upd_pc,
  output logic [31:0]      bp_upd_target,
  output logic             bp_upd_taken,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispred_count,
  output logic             err_illegal_cmpop
);

  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, REDIRECT, DRAIN} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [31:0]       rpc_q, rpc_d;
  logic              rv_q, flush_q;
  logic              upd_v_q, upd_tk_q, err_q;
  logic [31:0]       upd_pc_q, upd_tgt_q;
  logic [CNT_W-1:0]  br_cnt_q, mis_cnt_q;

  logic              resolve, illegal, taken, mispred;
  logic [31:0]       act_target;
  logic              unused_cmp_hi;

  assign cmpop         = ex_cmpop;
  assign unused_cmp_hi = ^cmp_br_en[31:1];

  always_comb begin
    resolve    = (state_q == IDLE) & ex_valid & (ex_is_br | ex_is_jal | ex_is_jalr);
    // funct3 010/011 have no branch meaning; such a branch is forced not-taken
    illegal    = ex_is_br & (ex_cmpop[2:1] == 2'b01);
    taken      = ex_is_jal | ex_is_jalr | (ex_is_br & cmp_br_en[0] & ~illegal);
    act_target = taken ? ex_target : ex_pc + 32'd4;
    mispred    = (taken != ex_pred_taken) | (taken & (ex_target != ex_pred_target));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rpc_d   = rpc_q;
    case (state_q)
      IDLE: if (resolve & mispred) begin
        state_d = REDIRECT;
        rpc_d   = act_target;
      end
      // redirect_valid is high throughout REDIRECT, so ready alone completes it
      REDIRECT: if (redirect_ready) begin
        if (FLUSH_CYCLES == 0) state_d = IDLE;
        else begin
          state_d = DRAIN;
          cnt_d   = CW'(FLUSH_CYCLES - 1);
        end
      end
      DRAIN: if (cnt_q == '0) state_d = IDLE;
             else cnt_d = cnt_q - CW'(1);
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rpc_q     <= '0;
      rv_q      <= 1'b0;
      flush_q   <= 1'b0;
      upd_v_q   <= 1'b0;
      upd_tk_q  <= 1'b0;
      upd_pc_q  <= '0;
      upd_tgt_q <= '0;
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rpc_q   <= rpc_d;
      rv_q    <= (state_d == REDIRECT);
      flush_q <= (state_d != IDLE);
      upd_v_q <= resolve;
      if (resolve) begin
        upd_tk_q  <= taken;
        upd_pc_q  <= ex_pc;
        upd_tgt_q <= act_target;
        if (br_cnt_q != '1) br_cnt_q <= br_cnt_q + CNT_W'(1);
        if (mispred && mis_cnt_q != '1) mis_cnt_q <= mis_cnt_q + CNT_W'(1);
        if (illegal) err_q <= 1'b1;
      end
    end
  end

  assign redirect_valid    = rv_q;
  assign redirect_pc       = rpc_q;
  assign flush_if_id       = flush_q;
  assign flush_id_ex       = flush_q;
  assign ex_stall          = flush_q;
  assign bp_upd_valid      = upd_v_q;
  assign bp_upd_pc         = upd_pc_q;
  assign bp_upd_target     = upd_tgt_q;
  assign bp_upd_taken      = upd_tk_q;
  assign br_count          = br_cnt_q;
  assign mispred_count     = mis_cnt_q;
  assign err_illegal_cmpop = err_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Bench for branch_resolve_ctrl: directed scenarios then random traffic,
// all outputs compared each cycle against a rule-level reference model.
module tb_branch_resolve_ctrl;
  localparam int FC = 1;
  localparam int CW = 4;
  localparam int SAT = (1 << CW) - 1;

  logic clk = 1'b0, rst_n;
  logic ex_valid, ex_is_br, ex_is_jal, ex_is_jalr, ex_pred_taken, redirect_ready;
  logic [2:0] ex_cmpop, cmpop;
  logic [31:0] ex_pc, ex_target, ex_pred_target, cmp_br_en;
  logic redirect_valid, flush_if_id, flush_id_ex, ex_stall;
  logic bp_upd_valid, bp_upd_taken, err_illegal_cmpop;
  logic [31:0] redirect_pc, bp_upd_pc, bp_upd_target;
  logic [CW-1:0] br_count, mispred_count;

  int checks = 0, failures = 0;

  // model: pending redirect flag/pc, remaining flush cycles after handshake
  bit m_rv, m_upd_v, m_upd_tk, m_err;
  int m_drain, m_br, m_mis;
  logic [31:0] m_rpc, m_upd_pc, m_upd_tgt;

  branch_resolve_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_is_br(ex_is_br),
    .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr), .ex_cmpop(ex_cmpop),
    .ex_pc(ex_pc), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target), .cmpop(cmpop), .cmp_br_en(cmp_br_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready), .flush_if_id(flush_if_id),
    .flush_id_ex(flush_id_ex), .ex_stall(ex_stall), .bp_upd_valid(bp_upd_valid),
    .bp_upd_pc(bp_upd_pc), .bp_upd_target(bp_upd_target), .bp_upd_taken(bp_upd_taken),
    .br_count(br_count), .mispred_count(mispred_count),
    .err_illegal_cmpop(err_illegal_cmpop));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_rv = 0; m_drain = 0; m_rpc = 0; m_upd_v = 0; m_upd_tk = 0;
    m_upd_pc = 0; m_upd_tgt = 0; m_br = 0; m_mis = 0; m_err = 0;
  endtask

  task automatic model_edge();
    bit ill, tk, mis;
    logic [31:0] tgt;
    m_upd_v = 0;
    if (!m_rv && m_drain == 0) begin
      if (ex_valid && (ex_is_br || ex_is_jal || ex_is_jalr)) begin
        ill = ex_is_br && (ex_cmpop == 3'd2 || ex_cmpop == 3'd3);
        tk  = ex_is_jal || ex_is_jalr || (ex_is_br && cmp_br_en[0] && !ill);
        tgt = tk ? ex_target : ex_pc + 32'd4;
        mis = (tk != ex_pred_taken) || (tk && ex_target != ex_pred_target);
        m_upd_v = 1; m_upd_tk = tk; m_upd_pc = ex_pc; m_upd_tgt = tgt;
        if (m_br < SAT) m_br++;
        if (mis && m_mis < SAT) m_mis++;
        if (ill) m_err = 1;
        if (mis) begin m_rv = 1; m_rpc = tgt; end
      end
    end else if (m_rv) begin
      if (redirect_ready) begin m_rv = 0; m_drain = FC; end
    end else m_drain--;
  endtask

  task automatic check_all();
    bit fl;
    fl = m_rv || m_drain > 0;
    chk("cmpop", {29'd0, cmpop}, {29'd0, ex_cmpop});
    chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, m_rv});
    if (m_rv) chk("redirect_pc", redirect_pc, m_rpc);
    chk("flush_if_id", {31'd0, flush_if_id}, {31'd0, fl});
    chk("flush_id_ex", {31'd0, flush_id_ex}, {31'd0, fl});
    chk("ex_stall", {31'd0, ex_stall}, {31'd0, fl});
    chk("bp_upd_valid", {31'd0, bp_upd_valid}, {31'd0, m_upd_v});
    if (m_upd_v) begin
      chk("bp_upd_pc", bp_upd_pc, m_upd_pc);
      chk("bp_upd_taken", {31'd0, bp_upd_taken}, {31'd0, m_upd_tk});
      chk("bp_upd_target", bp_upd_target, m_upd_tgt);
    end
    chk("br_count", {28'd0, br_count}, m_br);
    chk("mispred_count", {28'd0, mispred_count}, m_mis);
    chk("err_illegal_cmpop", {31'd0, err_illegal_cmpop}, {31'd0, m_err});
  endtask

  task automatic step();
    model_edge();
    @(posedge clk); #1;
    check_all();
  endtask

  task automatic drive(input bit v, input bit br, input bit jal, input bit jalr,
                       input logic [2:0] op, input logic [31:0] pc, input logic [31:0] tgt,
                       input bit pt, input logic [31:0] ptgt, input bit en);
    ex_valid = v; ex_is_br = br; ex_is_jal = jal; ex_is_jalr = jalr; ex_cmpop = op;
    ex_pc = pc; ex_target = tgt; ex_pred_taken = pt; ex_pred_target = ptgt;
    cmp_br_en = {31'd0, en};
  endtask

  task automatic idle_in();
    drive(0, 0, 0, 0, 3'd0, 32'h0, 32'h0, 0, 32'h0, 0);
  endtask

  task automatic check_reset_zero(input string tag);
    chk({tag, "_rv"}, {31'd0, redirect_valid}, 32'd0);
    chk({tag, "_rpc"}, redirect_pc, 32'd0);
    chk({tag, "_flush"}, {30'd0, flush_if_id, flush_id_ex}, 32'd0);
    chk({tag, "_stall"}, {31'd0, ex_stall}, 32'd0);
    chk({tag, "_upd"}, {31'd0, bp_upd_valid}, 32'd0);
    chk({tag, "_cnt"}, {24'd0, br_count, mispred_count}, 32'd0);
    chk({tag, "_err"}, {31'd0, err_illegal_cmpop}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; redirect_ready = 1'b0; idle_in(); m_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 check_reset_zero("reset");
    check_all();
    @(posedge clk); #1;

    // correctly predicted taken beq
    drive(1, 1, 0, 0, 3'b000, 32'h40, 32'h100, 1, 32'h100, 1);
    step();
    chk("beq_upd_pc", bp_upd_pc, 32'h40);
    chk("beq_upd_tgt", bp_upd_target, 32'h100);
    idle_in(); step();

    // bne not taken but predicted taken; fetch holds off for 3 cycles
    drive(1, 1, 0, 0, 3'b001, 32'h80, 32'h300, 1, 32'h300, 0);
    step();
    chk("bne_rpc", redirect_pc, 32'h84);
    idle_in();
    repeat (3) step();
    redirect_ready = 1'b1; step();
    redirect_ready = 1'b0; step();
    chk("bne_mis", {28'd0, mispred_count}, 32'd1);
    step();

    // jalr target mismatch
    drive(1, 0, 0, 1, 3'b000, 32'h500, 32'h204, 1, 32'h200, 0);
    step();
    chk("jalr_rpc", redirect_pc, 32'h204);
    idle_in(); redirect_ready = 1'b1; step(); step();

    // pc+4 wraps to zero
    drive(1, 1, 0, 0, 3'b100, 32'hFFFF_FFFC, 32'h10, 1, 32'h10, 0);
    step();
    chk("wrap_rpc", redirect_pc, 32'h0);
    idle_in(); step(); step();

    // reset in the middle of a stalled redirect
    redirect_ready = 1'b0;
    drive(1, 0, 1, 0, 3'b000, 32'h600, 32'h700, 0, 32'h0, 0);
    step(); idle_in(); step();
    rst_n = 1'b0;
    #1 m_reset();
    check_reset_zero("midrst");
    @(posedge clk); #1 rst_n = 1'b1;
    step();

    // 20 correct branches saturate the 4-bit counter
    for (int i = 0; i < 20; i++) begin
      drive(1, 1, 0, 0, 3'b101, 32'h1000 + 32'(i * 4), 32'h2000, 1, 32'h2000, 1);
      step();
    end
    chk("sat_br", {28'd0, br_count}, 32'd15);

    // illegal funct3 on a branch: not taken regardless of comparator
    drive(1, 1, 0, 0, 3'b010, 32'h3000, 32'h4000, 0, 32'h0, 1);
    step();
    chk("ill_taken", {31'd0, bp_upd_taken}, 32'd0);
    chk("ill_err", {31'd0, err_illegal_cmpop}, 32'd1);
    idle_in(); repeat (3) step();

    // random traffic; small address pool so predictions sometimes match
    for (int i = 0; i < 400; i++) begin
      ex_valid = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 4))
        0: {ex_is_br, ex_is_jal, ex_is_jalr} = 3'b000;
        1: {ex_is_br, ex_is_jal, ex_is_jalr} = 3'b010;
        2: {ex_is_br, ex_is_jal, ex_is_jalr} = 3'b001;
        default: {ex_is_br, ex_is_jal, ex_is_jalr} = 3'b100;
      endcase
      ex_cmpop       = 3'($urandom_range(0, 7));
      ex_pc          = {$urandom_range(0, 255), 2'b00};
      ex_target      = 32'h8000 + 32'($urandom_range(0, 3) * 4);
      ex_pred_target = 32'h8000 + 32'($urandom_range(0, 3) * 4);
      ex_pred_taken  = 1'($urandom_range(0, 1));
      cmp_br_en      = $urandom;
      redirect_ready = ($urandom_range(0, 2) != 0);
      step();
    end

    // sticky error clears only through reset
    rst_n = 1'b0;
    #1 m_reset();
    chk("final_err", {31'd0, err_illegal_cmpop}, 32'd0);
    check_reset_zero("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
